// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the fetch redirect sequencer.
package fetch_sequencer_pkg;

  localparam int WORD_LEN_DEFAULT = 16;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } seqState_t;

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_reg.sv
// Load-enabled register with asynchronous clear; holds the pending redirect offset.
module fetch_sequencer_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Steers IF-stage redirects from ID, deferring them while instruction memory is not ready.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int WORD_LEN = fetch_sequencer_pkg::WORD_LEN_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard_stall,
  input  logic                br_req,
  input  logic                jmp_req,
  input  logic [WORD_LEN-1:0] req_offset,
  input  logic                imem_ready,
  output logic                freeze,
  output logic                brTaken,
  output logic                IsJump,
  output logic [WORD_LEN-1:0] brOffset,
  output logic                flush,
  output logic                pend_valid,
  output logic [7:0]          stall_cnt,
  output logic [7:0]          redir_cnt
);

  seqState_t           stateReg, stateNext;
  logic                pendJumpReg;
  logic [WORD_LEN-1:0] pendOffset;
  logic                latchEn;
  logic                reqValid;
  logic [7:0]          stallCntReg, redirCntReg;

  // Requests raised during a hazard are re-presented by ID later, so drop them here.
  assign reqValid = (br_req | jmp_req) & ~hazard_stall;

  fetch_sequencer_reg #(.WIDTH(WORD_LEN)) pendOffsetReg (
    .clk (clk),
    .rst (rst),
    .en  (latchEn),
    .d   (req_offset),
    .q   (pendOffset)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= RUN;
      pendJumpReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (latchEn) begin
        pendJumpReg <= jmp_req;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    latchEn   = 1'b0;
    freeze    = 1'b0;
    brTaken   = 1'b0;
    IsJump    = 1'b0;
    brOffset  = '0;
    flush     = 1'b0;
    case (stateReg)
      RUN: begin
        if (reqValid && imem_ready) begin
          flush    = 1'b1;
          brOffset = req_offset;
          IsJump   = jmp_req;
          brTaken  = ~jmp_req;
        end else if (reqValid) begin
          freeze    = 1'b1;
          latchEn   = 1'b1;
          stateNext = PEND;
        end else begin
          freeze = hazard_stall | ~imem_ready;
        end
      end
      PEND: begin
        // The latched redirect wins over anything ID presents now, hazards included.
        if (imem_ready) begin
          flush     = 1'b1;
          brOffset  = pendOffset;
          IsJump    = pendJumpReg;
          brTaken   = ~pendJumpReg;
          stateNext = RUN;
        end else begin
          freeze = 1'b1;
        end
      end
      default: stateNext = RUN;
    endcase
    if (rst) begin
      stateNext = RUN;
      latchEn   = 1'b0;
      freeze    = 1'b0;
      brTaken   = 1'b0;
      IsJump    = 1'b0;
      brOffset  = '0;
      flush     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntReg <= 8'd0;
      redirCntReg <= 8'd0;
    end else begin
      if (freeze) begin
        stallCntReg <= satInc8(stallCntReg);
      end
      if (flush) begin
        redirCntReg <= redirCntReg + 8'd1;
      end
    end
  end

  assign pend_valid = ~rst & (stateReg == PEND);
  assign stall_cnt  = stallCntReg;
  assign redir_cnt  = redirCntReg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against a pending-redirect reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard_stall = 1'b0;
  logic        br_req = 1'b0;
  logic        jmp_req = 1'b0;
  logic [15:0] req_offset = 16'h0000;
  logic        imem_ready = 1'b0;
  logic        freeze, brTaken, IsJump, flush, pend_valid;
  logic [15:0] brOffset;
  logic [7:0]  stall_cnt, redir_cnt;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // Reference model: a redirect waiting for memory, plus event counters.
  bit          mHave = 1'b0;
  bit          mJump = 1'b0;
  logic [15:0] mOff = 16'h0000;
  int          mStalls = 0;
  int          mRedirs = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.WORD_LEN(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard_stall (hazard_stall),
    .br_req       (br_req),
    .jmp_req      (jmp_req),
    .req_offset   (req_offset),
    .imem_ready   (imem_ready),
    .freeze       (freeze),
    .brTaken      (brTaken),
    .IsJump       (IsJump),
    .brOffset     (brOffset),
    .flush        (flush),
    .pend_valid   (pend_valid),
    .stall_cnt    (stall_cnt),
    .redir_cnt    (redir_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  task automatic checkAll(input bit eFreeze, input bit eBr, input bit eJmp, input logic [15:0] eOff,
                          input bit eFlush, input bit ePend);
    chk("freeze", {15'd0, freeze}, {15'd0, eFreeze});
    chk("brTaken", {15'd0, brTaken}, {15'd0, eBr});
    chk("IsJump", {15'd0, IsJump}, {15'd0, eJmp});
    chk("brOffset", brOffset, eOff);
    chk("flush", {15'd0, flush}, {15'd0, eFlush});
    chk("pend_valid", {15'd0, pend_valid}, {15'd0, ePend});
    chk("stall_cnt", {8'd0, stall_cnt}, 16'(mStalls));
    chk("redir_cnt", {8'd0, redir_cnt}, 16'(mRedirs));
  endtask

  // One cycle: drive, evaluate model from the rules, compare mid-cycle, advance.
  task automatic step(input bit haz, input bit br, input bit jmp, input logic [15:0] off, input bit rdy);
    bit eFreeze, eBr, eJmp, eFlush, ePend, valid;
    logic [15:0] eOff;
    hazard_stall = haz; br_req = br; jmp_req = jmp; req_offset = off; imem_ready = rdy;
    #4;
    eFreeze = 0; eBr = 0; eJmp = 0; eFlush = 0; eOff = 16'h0000;
    ePend = mHave;
    valid = (br | jmp) & ~haz;
    if (mHave) begin
      if (rdy) begin
        eFlush = 1; eJmp = mJump; eBr = ~mJump; eOff = mOff; mHave = 0;
      end else begin
        eFreeze = 1;
      end
    end else if (valid && rdy) begin
      eFlush = 1; eJmp = jmp; eBr = ~jmp; eOff = off;
    end else if (valid) begin
      eFreeze = 1; mHave = 1; mJump = jmp; mOff = off;
    end else begin
      eFreeze = haz | ~rdy;
    end
    checkAll(eFreeze, eBr, eJmp, eOff, eFlush, ePend);
    $display("cyc %0d haz=%0b br=%0b jmp=%0b off=%h rdy=%0b -> frz=%0b bt=%0b ij=%0b bo=%h fl=%0b pv=%0b sc=%0d rc=%0d",
             cycle, haz, br, jmp, off, rdy, freeze, brTaken, IsJump, brOffset, flush, pend_valid,
             stall_cnt, redir_cnt);
    if (eFreeze) mStalls = (mStalls < 255) ? mStalls + 1 : 255;
    if (eFlush) mRedirs = (mRedirs + 1) % 256;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Asynchronous reset pulse raised mid-cycle; everything must read zero while it is held.
  task automatic pulseReset();
    rst = 1'b1;
    #3;
    mHave = 0; mStalls = 0; mRedirs = 0;
    checkAll(0, 0, 0, 16'h0000, 0, 0);
    $display("cyc %0d reset asserted", cycle);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle++;
  endtask

  initial begin
    int n;
    logic [15:0] rOff;
    @(posedge clk);
    #1;
    pulseReset();

    // Same-cycle branch.
    step(0, 1, 0, 16'h0004, 1);
    chk("redir_after_branch", {8'd0, redir_cnt}, 16'd1);
    // Simultaneous jump and branch: jump wins, one flush.
    step(0, 1, 1, 16'h0010, 1);
    step(0, 0, 0, 16'h0000, 1);
    // Memory wait with branch latched.
    step(0, 1, 0, 16'h0008, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0000, 0);
    step(0, 0, 1, 16'h0777, 1);
    step(0, 0, 0, 16'h0000, 1);
    // Hazard drops the request.
    step(1, 1, 0, 16'h0020, 1);
    step(1, 1, 0, 16'h0020, 0);
    step(0, 0, 0, 16'h0000, 1);
    // Reset while pending: redirect discarded.
    step(0, 0, 1, 16'h0030, 0);
    step(0, 1, 0, 16'h0040, 0);
    pulseReset();
    step(0, 0, 0, 16'h0000, 1);
    step(0, 0, 0, 16'h0000, 1);
    chk("no_redir_after_reset", {8'd0, redir_cnt}, 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 99);
      rOff = 16'($urandom);
      step(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 20),
           rOff, (n < 70));
      if ($urandom_range(0, 199) == 0) pulseReset();
    end

    // Saturation of the stall counter.
    pulseReset();
    for (int i = 0; i < 300; i++) step(1, 0, 0, 16'h0000, 1);
    chk("stall_saturated", {8'd0, stall_cnt}, 16'd255);
    step(0, 0, 0, 16'h0000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
